// File: rtl/pe_array_stim_gen.sv
// rtl/pe_array_stim_gen.sv - burst/gap stimulus generator feeding a PE array over a valid/ready link
// Three data patterns (increment, Galois LFSR, walking one); data advances only on accepted transfers.
module pe_array_stim_gen #(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_LANES  = 4,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] SEED       = 32'h0000_0001
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            start,
    input  logic                            abort,
    input  logic [1:0]                      mode,
    input  logic [CNT_WIDTH-1:0]            burst_len,
    input  logic [7:0]                      gap_len,
    input  logic [CNT_WIDTH-1:0]            num_bursts,
    output logic                            ivalid,
    input  logic                            iready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] idata,
    output logic                            busy,
    output logic                            done,
    output logic [CNT_WIDTH-1:0]            xfer_count
);

    localparam logic [31:0]           LFSR_TAPS = 32'h8020_0003;
    localparam int                    WALK_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DATA_WIDTH-1:0] LANE_ONE  = DATA_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [1:0]                      r_mode;
    logic [CNT_WIDTH-1:0]            r_burst_len;
    logic [7:0]                      r_gap_len;
    logic [CNT_WIDTH-1:0]            r_num_bursts;
    logic [CNT_WIDTH-1:0]            r_beat_cnt;
    logic [CNT_WIDTH-1:0]            r_burst_cnt;
    logic [7:0]                      r_gap_cnt;
    logic [CNT_WIDTH-1:0]            r_xfer_count;
    logic [DATA_WIDTH-1:0]           r_base;
    logic [WALK_W-1:0]               r_walk;
    logic [31:0]                     r_lfsr;

    logic                            w_launch;
    logic                            w_xfer;
    logic                            w_burst_end;
    logic                            w_last_burst;
    logic                            w_gap_end;
    logic [31:0]                     w_lfsr_next;
    logic [NUM_LANES*DATA_WIDTH-1:0] w_pattern;

    assign w_launch     = (r_state == S_IDLE) && start && !abort;
    assign w_xfer       = (r_state == S_BURST) && iready;
    assign w_burst_end  = w_xfer && (r_beat_cnt == r_burst_len - CNT_WIDTH'(1));
    assign w_last_burst = (r_burst_cnt == r_num_bursts - CNT_WIDTH'(1));
    assign w_gap_end    = (r_state == S_GAP) && (r_gap_cnt == r_gap_len - 8'd1);
    assign w_lfsr_next  = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_next = (num_bursts == '0) ? S_DONE : S_BURST;
                end
            end
            S_BURST: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_burst_end) begin
                    if (w_last_burst) begin
                        w_next = S_DONE;
                    end else if (r_gap_len != 8'd0) begin
                        w_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_gap_end) begin
                    w_next = S_BURST;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_mode       <= 2'd0;
            r_burst_len  <= '0;
            r_gap_len    <= 8'd0;
            r_num_bursts <= '0;
            r_beat_cnt   <= '0;
            r_burst_cnt  <= '0;
            r_gap_cnt    <= 8'd0;
            r_xfer_count <= '0;
            r_base       <= '0;
            r_walk       <= '0;
            r_lfsr       <= SEED;
        end else if (w_launch) begin
            r_mode       <= (mode == 2'd3) ? 2'd0 : mode;
            r_burst_len  <= (burst_len == '0) ? CNT_WIDTH'(1) : burst_len;
            r_gap_len    <= gap_len;
            r_num_bursts <= num_bursts;
            r_beat_cnt   <= '0;
            r_burst_cnt  <= '0;
            r_gap_cnt    <= 8'd0;
            r_xfer_count <= '0;
            r_base       <= '0;
            r_walk       <= '0;
            r_lfsr       <= SEED;
        end else begin
            // A handshake that coincides with abort still counts: the sink took the word.
            if (w_xfer) begin
                r_xfer_count <= r_xfer_count + CNT_WIDTH'(1);
                r_base       <= r_base + DATA_WIDTH'(NUM_LANES);
                r_walk       <= (r_walk == WALK_W'(DATA_WIDTH - 1)) ? '0 : r_walk + WALK_W'(1);
                r_lfsr       <= w_lfsr_next;
                if (w_burst_end) begin
                    r_beat_cnt  <= '0;
                    r_burst_cnt <= r_burst_cnt + CNT_WIDTH'(1);
                end else begin
                    r_beat_cnt  <= r_beat_cnt + CNT_WIDTH'(1);
                end
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= w_gap_end ? 8'd0 : r_gap_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_pattern = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            case (r_mode)
                2'd1:    w_pattern[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(r_lfsr) ^ DATA_WIDTH'(k);
                2'd2:    w_pattern[k*DATA_WIDTH +: DATA_WIDTH] = LANE_ONE << ((int'(r_walk) + k) % DATA_WIDTH);
                default: w_pattern[k*DATA_WIDTH +: DATA_WIDTH] = r_base + DATA_WIDTH'(k);
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign ivalid     = (r_state == S_BURST);
    assign idata      = ivalid ? w_pattern : '0;
    assign busy       = (r_state == S_BURST) || (r_state == S_GAP);
    assign done       = (r_state == S_DONE);
    assign xfer_count = r_xfer_count;

endmodule
